if_id_queue: RTL and testbench

- Instruction queue between the fetch stage and the decode stage.
- Captures each fetched instruction and its PC, and buffers up to DEPTH entries in order.
- Presents the oldest entry to decode with a valid/ready handshake.
- Back-pressures fetch through stall_o, which connects to the fetch stall_i. Discards all contents on a branch redirect (flush_i).

---
 rtl/if_id_queue.sv | 113 +++++++++++
 tb/tb_if_id_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// if_id_queue: in-order instruction/PC queue between fetch and decode.
// Oldest entry is presented to decode under a valid/ready handshake.
// stall_o back-pressures fetch when the queue is full.
// flush_i discards every entry on a branch redirect.
//
// Handshakes:
//   Fetch side: an entry is taken when valid_i & ~stall_o & ~flush_i.
//   Decode side: the head is consumed when valid_o & ready_i & ~flush_i.
//   stall_o depends only on registered occupancy and never on ready_i.
//
// Optional feature, macro IFQ_BYPASS_EN:
//   When the queue is empty, fetch data is forwarded to decode in the same
//   cycle. If decode accepts it, the entry is never written.
//   When the macro is undefined, there is no combinational path from the
//   fetch inputs to the decode outputs.
module if_id_queue #(
  parameter int unsigned                PC_BITS    = 16,
  parameter int unsigned                INSTR_BITS = 32,
  parameter int unsigned                DEPTH      = 4,
  parameter logic [INSTR_BITS-1:0]      NOP_INSTR  = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [INSTR_BITS-1:0]         instr_i,
  input  logic [PC_BITS-1:0]            pc_i,
  input  logic                          valid_i,
  output logic                          stall_o,
  input  logic                          flush_i,
  output logic [INSTR_BITS-1:0]         instr_o,
  output logic [PC_BITS-1:0]            pc_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Entry storage. It is not reset because occupancy alone defines what is valid.
  logic [INSTR_BITS-1:0] r_instr_mem [DEPTH];
  logic [PC_BITS-1:0]    r_pc_mem    [DEPTH];

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_head_valid;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;

  assign w_head_valid = (r_count != '0);
  assign stall_o      = (r_count == CNT_W'(DEPTH));
  assign count_o      = r_count;

`ifdef IFQ_BYPASS_EN
  // An empty queue forwards the fetch data straight to decode.
  assign w_bypass = ~w_head_valid & valid_i & ~flush_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign valid_o = w_head_valid | w_bypass;

  // Pops only come from stored entries. A bypassed instruction that decode
  // accepts is consumed without touching the pointers or the count.
  assign w_pop  = w_head_valid & ready_i & ~flush_i;
  assign w_push = valid_i & ~stall_o & ~flush_i & ~(w_bypass & ready_i);

  // Head output mux. It drives NOP/0 whenever nothing valid is presented.
  always_comb begin
    instr_o = NOP_INSTR;
    pc_o    = '0;
    if (w_head_valid) begin
      instr_o = r_instr_mem[r_rd_ptr];
      pc_o    = r_pc_mem[r_rd_ptr];
    end else if (w_bypass) begin
      instr_o = instr_i;
      pc_o    = pc_i;
    end
  end

  // Write the accepted fetch entry at the write pointer.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= instr_i;
      r_pc_mem[r_wr_ptr]    <= pc_i;
    end
  end

  // Pointer and occupancy update. A flush overrides any push or pop in the
  // same cycle. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed and randomized checks of if_id_queue against a
// queue-based reference model. Fetch is modelled as holding its instruction
// until it is accepted.
module tb_if_id_queue;

  localparam int PC_BITS    = 16;
  localparam int INSTR_BITS = 32;
  localparam int DEPTH      = 4;
  localparam logic [INSTR_BITS-1:0] NOP = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk_i = 1'b0;
  logic                   rst_n_i;
  logic [INSTR_BITS-1:0]  instr_i;
  logic [PC_BITS-1:0]     pc_i;
  logic                   valid_i;
  logic                   stall_o;
  logic                   flush_i;
  logic [INSTR_BITS-1:0]  instr_o;
  logic [PC_BITS-1:0]     pc_o;
  logic                   valid_o;
  logic                   ready_i;
  logic [$clog2(DEPTH):0] count_o;

  if_id_queue #(
    .PC_BITS(PC_BITS), .INSTR_BITS(INSTR_BITS), .DEPTH(DEPTH), .NOP_INSTR(NOP)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .instr_i(instr_i), .pc_i(pc_i),
    .valid_i(valid_i), .stall_o(stall_o), .flush_i(flush_i),
    .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i),
    .count_o(count_o)
  );

  // Clock and reset block.
  always #5 clk_i = ~clk_i;

  // Scoreboard: each entry is {instr, pc}, with the oldest entry at the front.
  logic [INSTR_BITS+PC_BITS-1:0] exp_q[$];
  int vectors    = 0;
  int miscompares = 0;

  logic [PC_BITS-1:0]    next_pc;
  logic [INSTR_BITS-1:0] cur_instr;
  bit                    accepted;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare the decode-side outputs against the model for the current inputs.
  task automatic check_outputs();
    int n;
    bit byp;
    logic [INSTR_BITS-1:0] ei;
    logic [PC_BITS-1:0]    ep;
    n   = exp_q.size();
    byp = BYP && (n == 0) && valid_i && !flush_i;
    if (n > 0) begin
      {ei, ep} = exp_q[0];
    end else if (byp) begin
      ei = instr_i;
      ep = pc_i;
    end else begin
      ei = NOP;
      ep = '0;
    end
    chk("valid_o", 64'(valid_o), 64'((n > 0) || byp));
    chk("instr_o", 64'(instr_o), 64'(ei));
    chk("pc_o",    64'(pc_o),    64'(ep));
    chk("count_o", 64'(count_o), 64'(n));
    chk("stall_o", 64'(stall_o), 64'(n == DEPTH));
  endtask

  // Apply the queue rules at a rising edge, using the inputs that were
  // presented during the preceding cycle.
  task automatic model_edge();
    int  n;
    bit  do_pop, do_push;
    n        = exp_q.size();
    accepted = 1'b0;
    if (flush_i) begin
      exp_q.delete();
    end else if (BYP && n == 0 && valid_i && ready_i) begin
      accepted = 1'b1;
    end else begin
      do_pop  = (n > 0) && ready_i;
      do_push = valid_i && (n < DEPTH);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back({instr_i, pc_i});
        accepted = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  // Driver: fetch presents next_pc and holds it until the queue accepts it.
  // A flush redirects fetch to a new PC.
  task automatic fetch(input bit v, input bit r, input bit f);
    valid_i = v;
    ready_i = r;
    flush_i = f;
    pc_i    = next_pc;
    instr_i = cur_instr;
    cycle();
    if (f) begin
      next_pc   = next_pc + 16'h0100;
      cur_instr = $urandom;
    end else if (v && accepted) begin
      next_pc   = next_pc + 16'h0004;
      cur_instr = $urandom;
    end
  endtask

  initial begin
    rst_n_i   = 1'b0;
    valid_i   = 1'b0;
    ready_i   = 1'b0;
    flush_i   = 1'b0;
    instr_i   = '0;
    pc_i      = '0;
    next_pc   = 16'h0004;
    cur_instr = $urandom;

    // Outputs while held in reset.
    #2;
    check_outputs();
    #10 rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Asynchronous reset asserted mid-cycle with three entries stored.
    repeat (3) fetch(1'b1, 1'b0, 1'b0);
    chk("pre_reset_count", 64'(count_o), 64'd3);
    valid_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_instr", 64'(instr_o), 64'(NOP));
    chk("rst_pc",    64'(pc_o),    64'd0);
    exp_q.delete();
    @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    next_pc = 16'h0004;

    // Fill: five pushes with decode stalled. The fifth push is held by fetch.
    repeat (5) fetch(1'b1, 1'b0, 1'b0);
    chk("fill_stall", 64'(stall_o), 64'd1);
    chk("fill_count", 64'(count_o), 64'd4);
    chk("fill_held_pc", 64'(next_pc), 64'h0014);
    fetch(1'b1, 1'b1, 1'b0);
    fetch(1'b1, 1'b0, 1'b0);
    chk("fill_after_pop", 64'(next_pc), 64'h0018);

    // Drain from full. The model checks the PC order each cycle.
    repeat (5) fetch(1'b0, 1'b1, 1'b0);
    chk("drain_valid", 64'(valid_o), 64'd0);
    chk("drain_instr", 64'(instr_o), 64'(NOP));

    // Concurrent push and pop at occupancy 2. The pointers wrap past DEPTH.
    repeat (2) fetch(1'b1, 1'b0, 1'b0);
    repeat (10) fetch(1'b1, 1'b1, 1'b0);
    chk("conc_count", 64'(count_o), 64'd2);

    // Flush at occupancy 3, with a push and a pop requested in the same cycle.
    fetch(1'b1, 1'b0, 1'b0);
    chk("pre_flush_count", 64'(count_o), 64'd3);
    fetch(1'b1, 1'b1, 1'b1);
    valid_i = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(valid_o), 64'd0);
    chk("flush_stall", 64'(stall_o), 64'd0);
    fetch(1'b1, 1'b0, 1'b0);
    chk("flush_next_head", 64'(pc_o), 64'(next_pc - 16'h0004));

    // Empty queue with push and pop requested together (bypass case).
    repeat (2) fetch(1'b0, 1'b1, 1'b0);
    next_pc = 16'h0100;
    fetch(1'b1, 1'b1, 1'b0);
    valid_i = 1'b0;
    ready_i = 1'b0;
    #1;
    chk("byp_count", 64'(count_o), BYP ? 64'd0 : 64'd1);
    chk("byp_valid", 64'(valid_o), BYP ? 64'd0 : 64'd1);
    if (!BYP) chk("byp_pc", 64'(pc_o), 64'h0100);

    // Random traffic, first biased toward filling and then toward draining.
    repeat (200) fetch($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 24) == 0);
    repeat (200) fetch($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 24) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Bound on total simulation time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
